// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the fetch PC, reads the combinational
// instruction memory and queues {instr, pc} pairs toward decode.
module instr_fetch_unit #(
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned RESET_PC = 0
) (
    input  logic                         clk,
    input  logic                         reset,
    output logic [ADDR_W-1:0]            imem_addr,
    input  logic [DATA_W-1:0]            imem_rd,
    input  logic                         fetch_en,
    input  logic                         redirect_valid,
    input  logic [ADDR_W-1:0]            redirect_pc,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DATA_W-1:0]            out_instr,
    output logic [ADDR_W-1:0]            out_pc,
    output logic [$clog2(DEPTH):0]       fifo_count,
    output logic                         align_err
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              valid_q, valid_d;
    logic              align_err_q, align_err_d;
    logic [DATA_W-1:0] instr_q [DEPTH];
    logic [DATA_W-1:0] instr_d [DEPTH];
    logic [ADDR_W-1:0] pc_q    [DEPTH];
    logic [ADDR_W-1:0] pc_d    [DEPTH];

    logic              pop_c;
    logic              push_c;
    logic [CNT_W-1:0]  wr_idx_c;

    // Handshake qualifiers; entry 0 of the shift queue is always the head.
    assign pop_c    = valid_q & out_ready;
    assign push_c   = fetch_en & ~redirect_valid & ((count_q < CNT_W'(DEPTH)) | pop_c);
    assign wr_idx_c = pop_c ? (count_q - CNT_W'(1)) : count_q;

    // Next-state: redirect flushes and reloads PC, else shift on pop and append on push.
    always_comb begin
        fetch_pc_d  = fetch_pc_q;
        count_d     = count_q;
        align_err_d = redirect_valid & (|redirect_pc[1:0]);
        for (int unsigned i = 0; i < DEPTH; i++) begin
            instr_d[i] = instr_q[i];
            pc_d[i]    = pc_q[i];
        end

        if (redirect_valid) begin
            count_d    = '0;
            fetch_pc_d = {redirect_pc[ADDR_W-1:2], 2'b00};
        end else begin
            if (pop_c) begin
                for (int unsigned i = 0; i < DEPTH - 1; i++) begin
                    instr_d[i] = instr_q[i+1];
                    pc_d[i]    = pc_q[i+1];
                end
            end
            if (push_c) begin
                for (int unsigned i = 0; i < DEPTH; i++) begin
                    if (CNT_W'(i) == wr_idx_c) begin
                        instr_d[i] = imem_rd;
                        pc_d[i]    = fetch_pc_q;
                    end
                end
                // Wraps modulo 2^ADDR_W with no indication.
                fetch_pc_d = fetch_pc_q + ADDR_W'(4);
            end
            count_d = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
        end

        valid_d = (count_d != '0);
    end

    // State registers; reset clears the queue and restores the boot PC.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc_q  <= ADDR_W'(RESET_PC);
            count_q     <= '0;
            valid_q     <= 1'b0;
            align_err_q <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                instr_q[i] <= '0;
                pc_q[i]    <= '0;
            end
        end else begin
            fetch_pc_q  <= fetch_pc_d;
            count_q     <= count_d;
            valid_q     <= valid_d;
            align_err_q <= align_err_d;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                instr_q[i] <= instr_d[i];
                pc_q[i]    <= pc_d[i];
            end
        end
    end

    assign imem_addr  = fetch_pc_q;
    assign out_valid  = valid_q;
    assign out_instr  = instr_q[0];
    assign out_pc     = pc_q[0];
    assign fifo_count = count_q;
    assign align_err  = align_err_q;

endmodule
